// File: rtl/safe_pkg.sv
// Shared types and constants for the safe code datapath.
// Digit encoding, code word layout and the lockout state enumeration.
package safe_pkg;

    localparam int DEF_N_DIGITS = 4;
    localparam int DIGIT_MAX    = 9;

    typedef logic [3:0] digit_t;
    typedef digit_t [DEF_N_DIGITS-1:0] code_t;

    typedef enum logic {
        NORMAL     = 1'b0,
        LOCKED_OUT = 1'b1
    } lock_state_t;

    function automatic logic digit_ok(input digit_t d);
        return d <= digit_t'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/safe_code_path_if.sv
// Keypad / FSM handshake bundle between the unlock controller and the code datapath.
interface safe_code_path_if #(
    parameter int N_DIGITS = 4
);
    import safe_pkg::*;

    localparam int CNT_W = $clog2(N_DIGITS + 1);

    logic             KEY_VALID;
    digit_t           KEY_DIGIT;
    logic             CLEAR;
    logic             savePW;
    logic             saveAT;
    logic             MATCH;
    logic             LOCKOUT;
    logic [CNT_W-1:0] digit_count;
    logic [3:0]       fail_count;
    logic             bad_key;

    modport master (
        output KEY_VALID, KEY_DIGIT, CLEAR, savePW, saveAT,
        input  MATCH, LOCKOUT, digit_count, fail_count, bad_key
    );

    modport slave (
        input  KEY_VALID, KEY_DIGIT, CLEAR, savePW, saveAT,
        output MATCH, LOCKOUT, digit_count, fail_count, bad_key
    );

endinterface

// File: rtl/safe_entry_buf.sv
// Keypad entry buffer: shifts accepted digits in at the low nibble and flags rejected keys.
// Clear and capture both empty the buffer and swallow any same-cycle key without flagging it.
module safe_entry_buf
    import safe_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int CNT_W    = $clog2(N_DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    input  digit_t                key_digit,
    input  logic                  key_block,
    input  logic                  clear,
    input  logic                  capture,
    output digit_t [N_DIGITS-1:0] buffer,
    output logic   [CNT_W-1:0]    count,
    output logic                  bad_key
);

    digit_t [N_DIGITS-1:0] shifted;
    logic                  room;

    assign room = (count < CNT_W'(N_DIGITS));

    always_comb begin
        shifted = buffer;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            shifted[i] = buffer[i-1];
        end
        shifted[0] = key_digit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer  <= '0;
            count   <= '0;
            bad_key <= 1'b0;
        end else begin
            bad_key <= 1'b0;
            if (clear || capture) begin
                buffer <= '0;
                count  <= '0;
            end else if (key_valid && !key_block) begin
                if (digit_ok(key_digit) && room) begin
                    buffer <= shifted;
                    count  <= count + 1'b1;
                end else begin
                    bad_key <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/safe_code_path.sv
// Safe-unlock datapath: password/attempt capture, MATCH generation, failed-attempt
// counting and a timed lockout that blocks the keypad.
//
// state      | meaning
// NORMAL     | keypad live, attempts scored against the stored password
// LOCKED_OUT | keypad ignored, MATCH forced low, timer counts down to release
module safe_code_path
    import safe_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input logic             clk,
    input logic             RESETN,
    safe_code_path_if.slave bus
);

    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam int TW    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    logic                  save_pw_q, save_at_q;
    logic                  pw_cap, at_cap;
    digit_t [N_DIGITS-1:0] buffer;
    logic   [CNT_W-1:0]    count;
    logic                  bad_key;

    digit_t [N_DIGITS-1:0] pw_reg, at_reg;
    logic   [CNT_W-1:0]    pw_len, at_len;
    logic                  pw_valid, at_valid;
    logic                  attempt_ok;

    lock_state_t           state, state_next;
    logic   [TW-1:0]       timer, timer_next;
    logic   [3:0]          fail_count, fail_next;
    logic                  locked;

    // Password capture takes priority; a coincident attempt edge is discarded.
    assign pw_cap = bus.savePW && !save_pw_q;
    assign at_cap = bus.saveAT && !save_at_q && !pw_cap;
    assign locked = (state == LOCKED_OUT);

    safe_entry_buf #(
        .N_DIGITS (N_DIGITS),
        .CNT_W    (CNT_W)
    ) u_entry (
        .clk       (clk),
        .rst_n     (RESETN),
        .key_valid (bus.KEY_VALID),
        .key_digit (bus.KEY_DIGIT),
        .key_block (locked),
        .clear     (bus.CLEAR),
        .capture   (pw_cap || at_cap),
        .buffer    (buffer),
        .count     (count),
        .bad_key   (bad_key)
    );

    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            save_pw_q <= 1'b0;
            save_at_q <= 1'b0;
            pw_reg    <= '0;
            at_reg    <= '0;
            pw_len    <= '0;
            at_len    <= '0;
            pw_valid  <= 1'b0;
            at_valid  <= 1'b0;
        end else begin
            save_pw_q <= bus.savePW;
            save_at_q <= bus.saveAT;
            if (pw_cap) begin
                pw_reg   <= buffer;
                pw_len   <= count;
                pw_valid <= 1'b1;
                at_valid <= 1'b0;
            end else if (at_cap) begin
                at_reg   <= buffer;
                at_len   <= count;
                at_valid <= 1'b1;
            end
        end
    end

    // Scored against the live buffer so the verdict lands on the capture edge itself.
    assign attempt_ok = pw_valid && (count == pw_len) && (buffer == pw_reg);

    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            state      <= NORMAL;
            timer      <= '0;
            fail_count <= '0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            fail_count <= fail_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        fail_next  = fail_count;
        case (state)
            NORMAL: begin
                if (at_cap) begin
                    if (attempt_ok) begin
                        fail_next = '0;
                    end else begin
                        fail_next = (fail_count == 4'hF) ? 4'hF : fail_count + 4'd1;
                        if (fail_next >= 4'(MAX_FAILS)) begin
                            state_next = LOCKED_OUT;
                            timer_next = TW'(LOCKOUT_CYCLES - 1);
                        end
                    end
                end
            end
            LOCKED_OUT: begin
                if (timer == '0) begin
                    state_next = NORMAL;
                    fail_next  = '0;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            default: begin
                state_next = NORMAL;
            end
        endcase
    end

    assign bus.MATCH       = pw_valid && at_valid && (pw_len == at_len) &&
                             (pw_reg == at_reg) && !locked;
    assign bus.LOCKOUT     = locked;
    assign bus.digit_count = count;
    assign bus.fail_count  = fail_count;
    assign bus.bad_key     = bad_key;

endmodule

// File: tb/tb_safe_code_path.sv
// Self-checking bench for safe_code_path: directed scenarios plus a randomized run
// scored against a digit-queue model of the keypad, password and lockout rules.
module tb_safe_code_path;

    localparam int ND = 4;
    localparam int MF = 3;
    localparam int LC = 8;
    localparam int CW = $clog2(ND + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    safe_code_path_if #(.N_DIGITS(ND)) bus();

    safe_code_path #(
        .N_DIGITS       (ND),
        .MAX_FAILS      (MF),
        .LOCKOUT_CYCLES (LC)
    ) dut (
        .clk    (clk),
        .RESETN (rst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic lvl_pw = 1'b0;
    logic lvl_at = 1'b0;

    // Reference model: codes held as digit sequences, lockout as cycles remaining.
    int m_buf[$];
    int m_pw[$];
    int m_at[$];
    bit m_pw_valid, m_at_valid, m_bad, m_prev_pw, m_prev_at;
    int m_fails, m_lock_left;

    function automatic bit same_code(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_match();
        return m_pw_valid && m_at_valid && same_code(m_pw, m_at) && (m_lock_left == 0);
    endfunction

    task automatic model_reset();
        m_buf.delete(); m_pw.delete(); m_at.delete();
        m_pw_valid = 0; m_at_valid = 0; m_bad = 0; m_prev_pw = 0; m_prev_at = 0;
        m_fails = 0; m_lock_left = 0;
    endtask

    task automatic model_step(input bit kv, input int kd, input bit clr, input bit spw, input bit sat);
        bit pwc, atc, locked, ok;
        pwc = spw && !m_prev_pw;
        atc = sat && !m_prev_at && !pwc;
        locked = (m_lock_left > 0);
        m_bad = 0;
        if (pwc) begin
            m_pw = m_buf; m_pw_valid = 1; m_at_valid = 0; m_buf.delete();
        end else if (atc) begin
            ok = m_pw_valid && same_code(m_buf, m_pw);
            m_at = m_buf; m_at_valid = 1; m_buf.delete();
            if (!locked) begin
                if (ok) m_fails = 0;
                else begin
                    if (m_fails < 15) m_fails++;
                    if (m_fails >= MF) m_lock_left = LC;
                end
            end
        end else if (clr) begin
            m_buf.delete();
        end else if (kv && !locked) begin
            if (kd <= 9 && m_buf.size() < ND) m_buf.push_back(kd);
            else m_bad = 1;
        end
        if (locked) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end
        m_prev_pw = spw;
        m_prev_at = sat;
    endtask

    task automatic cycle(input bit kv, input int kd, input bit clr);
        bus.KEY_VALID = kv;
        bus.KEY_DIGIT = 4'(kd);
        bus.CLEAR     = clr;
        bus.savePW    = lvl_pw;
        bus.saveAT    = lvl_at;
        @(posedge clk);
        model_step(kv, kd, clr, lvl_pw, lvl_at);
        #1;
        bus.KEY_VALID = 1'b0;
        bus.CLEAR     = 1'b0;
    endtask

    task automatic enter_num(input int val, input int len);
        int p;
        for (int i = len - 1; i >= 0; i--) begin
            p = 1;
            for (int k = 0; k < i; k++) p = p * 10;
            cycle(1, (val / p) % 10, 0);
        end
    endtask

    task automatic attempt(input int val, input int len);
        enter_num(val, len);
        lvl_at = 1'b1; cycle(0, 0, 0);
        lvl_at = 1'b0; cycle(0, 0, 0);
    endtask

    task automatic set_pw(input int val, input int len);
        enter_num(val, len);
        lvl_pw = 1'b1; cycle(0, 0, 0);
        lvl_pw = 1'b0; cycle(0, 0, 0);
    endtask

    task automatic test_reset();
        bus.KEY_VALID = 0; bus.KEY_DIGIT = 0; bus.CLEAR = 0; bus.savePW = 0; bus.saveAT = 0;
        model_reset();
        #3;
        n_tests++; if (bus.MATCH !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %b want 0", bus.MATCH); end
        n_tests++; if (bus.LOCKOUT !== 1'b0) begin n_fail++; $display("FAIL reset_lockout: got %b want 0", bus.LOCKOUT); end
        n_tests++; if (bus.digit_count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.digit_count); end
        n_tests++; if (bus.fail_count !== 4'd0) begin n_fail++; $display("FAIL reset_fails: got %0d want 0", bus.fail_count); end
        n_tests++; if (bus.bad_key !== 1'b0) begin n_fail++; $display("FAIL reset_bad_key: got %b want 0", bus.bad_key); end
        #4 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        enter_num(1234, 4);
        lvl_pw = 1'b1;
        cycle(0, 0, 0);
        n_tests++; if (bus.digit_count !== CW'(0)) begin n_fail++; $display("FAIL pw_capture_clears: got %0d want 0", bus.digit_count); end
        for (int i = 0; i < 4; i++) cycle(1, 9, 0);
        n_tests++; if (bus.digit_count !== CW'(4)) begin n_fail++; $display("FAIL pw_single_capture: got %0d want 4", bus.digit_count); end
        lvl_pw = 1'b0;
        cycle(0, 0, 1);
        enter_num(1234, 4);
        lvl_at = 1'b1;
        cycle(0, 0, 0);
        n_tests++; if (bus.MATCH !== 1'b1) begin n_fail++; $display("FAIL basic_match: got %b want 1", bus.MATCH); end
        n_tests++; if (bus.fail_count !== 4'd0) begin n_fail++; $display("FAIL basic_fails: got %0d want 0", bus.fail_count); end
        lvl_at = 1'b0;
        cycle(0, 0, 0);
    endtask

    task automatic test_fail_count();
        attempt(1235, 4);
        n_tests++; if (bus.MATCH !== 1'b0) begin n_fail++; $display("FAIL wrong_match: got %b want 0", bus.MATCH); end
        n_tests++; if (bus.fail_count !== 4'd1) begin n_fail++; $display("FAIL fails_1: got %0d want 1", bus.fail_count); end
        attempt(12, 2);
        n_tests++; if (bus.fail_count !== 4'd2) begin n_fail++; $display("FAIL fails_2_short: got %0d want 2", bus.fail_count); end
        attempt(1234, 4);
        n_tests++; if (bus.MATCH !== 1'b1) begin n_fail++; $display("FAIL right_match: got %b want 1", bus.MATCH); end
        n_tests++; if (bus.fail_count !== 4'd0) begin n_fail++; $display("FAIL fails_cleared: got %0d want 0", bus.fail_count); end
    endtask

    task automatic test_lockout();
        int hi;
        attempt(1111, 4);
        attempt(1111, 4);
        enter_num(1111, 4);
        lvl_at = 1'b1; cycle(0, 0, 0);
        hi = int'(bus.LOCKOUT);
        n_tests++; if (bus.fail_count !== 4'd3) begin n_fail++; $display("FAIL lock_fails: got %0d want 3", bus.fail_count); end
        lvl_at = 1'b0; cycle(1, 5, 0); hi += int'(bus.LOCKOUT);
        n_tests++; if (bus.digit_count !== CW'(0)) begin n_fail++; $display("FAIL lock_key_ignored: got %0d want 0", bus.digit_count); end
        cycle(0, 0, 0); hi += int'(bus.LOCKOUT);
        n_tests++; if (bus.bad_key !== 1'b0) begin n_fail++; $display("FAIL lock_no_bad_key: got %b want 0", bus.bad_key); end
        lvl_pw = 1'b1; cycle(0, 0, 0); hi += int'(bus.LOCKOUT);
        lvl_pw = 1'b0; cycle(0, 0, 0); hi += int'(bus.LOCKOUT);
        lvl_at = 1'b1; cycle(0, 0, 0); hi += int'(bus.LOCKOUT);
        n_tests++; if (bus.MATCH !== 1'b0) begin n_fail++; $display("FAIL lock_match_forced: got %b want 0", bus.MATCH); end
        n_tests++; if (bus.fail_count !== 4'd3) begin n_fail++; $display("FAIL lock_fails_frozen: got %0d want 3", bus.fail_count); end
        lvl_at = 1'b0; cycle(0, 0, 0); hi += int'(bus.LOCKOUT);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0);
            if (bus.LOCKOUT) hi++;
            else break;
        end
        n_tests++; if (hi != LC) begin n_fail++; $display("FAIL lock_duration: got %0d cycles want %0d", hi, LC); end
        n_tests++; if (bus.fail_count !== 4'd0) begin n_fail++; $display("FAIL unlock_fails: got %0d want 0", bus.fail_count); end
        n_tests++; if (bus.MATCH !== 1'b1) begin n_fail++; $display("FAIL unlock_match_release: got %b want 1", bus.MATCH); end
        set_pw(1234, 4);
        attempt(1234, 4);
        n_tests++; if (bus.MATCH !== 1'b1) begin n_fail++; $display("FAIL unlock_attempt: got %b want 1", bus.MATCH); end
    endtask

    task automatic test_entry();
        cycle(0, 0, 1);
        for (int d = 1; d <= 4; d++) cycle(1, d, 0);
        n_tests++; if (bus.bad_key !== 1'b0) begin n_fail++; $display("FAIL entry_no_bad: got %b want 0", bus.bad_key); end
        cycle(1, 5, 0);
        n_tests++; if (bus.bad_key !== 1'b1) begin n_fail++; $display("FAIL full_bad_key: got %b want 1", bus.bad_key); end
        n_tests++; if (bus.digit_count !== CW'(4)) begin n_fail++; $display("FAIL full_count: got %0d want 4", bus.digit_count); end
        cycle(0, 0, 0);
        n_tests++; if (bus.bad_key !== 1'b0) begin n_fail++; $display("FAIL bad_key_pulse: got %b want 0", bus.bad_key); end
        lvl_pw = 1'b1; cycle(0, 0, 0);
        lvl_pw = 1'b0; cycle(0, 0, 0);
        attempt(1234, 4);
        n_tests++; if (bus.MATCH !== 1'b1) begin n_fail++; $display("FAIL fifth_dropped: got %b want 1", bus.MATCH); end
        cycle(1, 7, 0);
        cycle(1, 10, 0);
        n_tests++; if (bus.bad_key !== 1'b1) begin n_fail++; $display("FAIL digit_a_bad: got %b want 1", bus.bad_key); end
        n_tests++; if (bus.digit_count !== CW'(1)) begin n_fail++; $display("FAIL digit_a_count: got %0d want 1", bus.digit_count); end
        cycle(1, 3, 1);
        n_tests++; if (bus.digit_count !== CW'(0)) begin n_fail++; $display("FAIL clear_beats_key: got %0d want 0", bus.digit_count); end
        n_tests++; if (bus.bad_key !== 1'b0) begin n_fail++; $display("FAIL clear_no_bad: got %b want 0", bus.bad_key); end
    endtask

    task automatic test_priority();
        enter_num(12, 2);
        lvl_at = 1'b1; cycle(1, 3, 0);
        n_tests++; if (bus.digit_count !== CW'(0)) begin n_fail++; $display("FAIL cap_drops_key: got %0d want 0", bus.digit_count); end
        n_tests++; if (bus.bad_key !== 1'b0) begin n_fail++; $display("FAIL cap_no_bad: got %b want 0", bus.bad_key); end
        n_tests++; if (bus.fail_count !== 4'd1) begin n_fail++; $display("FAIL cap_fail: got %0d want 1", bus.fail_count); end
        lvl_at = 1'b0; cycle(0, 0, 0);
        enter_num(9, 1);
        lvl_pw = 1'b1; lvl_at = 1'b1; cycle(0, 0, 0);
        n_tests++; if (bus.MATCH !== 1'b0) begin n_fail++; $display("FAIL both_edges_match: got %b want 0", bus.MATCH); end
        n_tests++; if (bus.fail_count !== 4'd1) begin n_fail++; $display("FAIL both_edges_fails: got %0d want 1", bus.fail_count); end
        lvl_pw = 1'b0; lvl_at = 1'b0; cycle(0, 0, 0);
        attempt(9, 1);
        n_tests++; if (bus.MATCH !== 1'b1) begin n_fail++; $display("FAIL pw_won: got %b want 1", bus.MATCH); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) attempt(1, 1);
        n_tests++; if (bus.LOCKOUT !== 1'b1) begin n_fail++; $display("FAIL pre_reset_lock: got %b want 1", bus.LOCKOUT); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++; if (bus.LOCKOUT !== 1'b0) begin n_fail++; $display("FAIL async_lockout: got %b want 0", bus.LOCKOUT); end
        n_tests++; if (bus.fail_count !== 4'd0) begin n_fail++; $display("FAIL async_fails: got %0d want 0", bus.fail_count); end
        n_tests++; if (bus.MATCH !== 1'b0) begin n_fail++; $display("FAIL async_match: got %b want 0", bus.MATCH); end
        #2 rst_n = 1'b1;
        enter_num(56, 2);
        n_tests++; if (bus.digit_count !== CW'(2)) begin n_fail++; $display("FAIL mid_entry_count: got %0d want 2", bus.digit_count); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++; if (bus.digit_count !== CW'(0)) begin n_fail++; $display("FAIL async_count: got %0d want 0", bus.digit_count); end
        #2 rst_n = 1'b1;
        attempt(1234, 4);
        n_tests++; if (bus.MATCH !== 1'b0) begin n_fail++; $display("FAIL no_pw_match: got %b want 0", bus.MATCH); end
        n_tests++; if (bus.fail_count !== 4'd1) begin n_fail++; $display("FAIL no_pw_fails: got %0d want 1", bus.fail_count); end
    endtask

    task automatic test_random();
        bit kv, clr;
        int kd;
        for (int i = 0; i < 800; i++) begin
            kv  = ($urandom_range(0, 1) == 1);
            kd  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 1));
            clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) lvl_pw = ~lvl_pw;
            if ($urandom_range(0, 5) == 0) lvl_at = ~lvl_at;
            cycle(kv, kd, clr);
            n_tests++; if (bus.MATCH !== m_match()) begin n_fail++; $display("FAIL rnd_match @%0d: got %b want %b", i, bus.MATCH, m_match()); end
            n_tests++; if (bus.LOCKOUT !== (m_lock_left > 0)) begin n_fail++; $display("FAIL rnd_lockout @%0d: got %b want %b", i, bus.LOCKOUT, m_lock_left > 0); end
            n_tests++; if (bus.digit_count !== CW'(m_buf.size())) begin n_fail++; $display("FAIL rnd_count @%0d: got %0d want %0d", i, bus.digit_count, m_buf.size()); end
            n_tests++; if (bus.fail_count !== 4'(m_fails)) begin n_fail++; $display("FAIL rnd_fails @%0d: got %0d want %0d", i, bus.fail_count, m_fails); end
            n_tests++; if (bus.bad_key !== m_bad) begin n_fail++; $display("FAIL rnd_bad_key @%0d: got %b want %b", i, bus.bad_key, m_bad); end
        end
        lvl_pw = 1'b0;
        lvl_at = 1'b0;
        cycle(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fail_count();
        test_lockout();
        test_entry();
        test_priority();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/safe_code_path.md
Name: safe_code_path

Overview:
Datapath companion to the safe-unlock control FSM. It collects keypad digits into an entry buffer and captures that buffer as the password on a savePW rising edge, or as an attempt on a saveAT rising edge. It drives MATCH back to the FSM. It also counts failed attempts and enforces a timed lockout, during which keypad input is ignored and MATCH is held low.

Parameters:
N_DIGITS, 4, maximum code length in decimal digits (1..8)
MAX_FAILS, 3, consecutive mismatched attempts that trigger lockout (1..15)
LOCKOUT_CYCLES, 1000, clock cycles lockout stays asserted (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
RESETN  in  1  asynchronous active-low reset
KEY_VALID  in  1  one-cycle strobe: KEY_DIGIT is valid
KEY_DIGIT  in  4  digit value; only 0..9 accepted
CLEAR  in  1  empties entry buffer
savePW  in  1  level from FSM; rising edge captures password
saveAT  in  1  level from FSM; rising edge captures attempt
MATCH  out  1  stored attempt equals stored password
LOCKOUT  out  1  lockout active
digit_count  out  $clog2(N_DIGITS+1)  digits currently in entry buffer
fail_count  out  4  consecutive failed attempts
bad_key  out  1  one-cycle pulse: KEY_DIGIT > 9 offered, or digit offered while buffer full

Behaviour:
- Reset (async assert, sync release):
  - All buffers and registers zero; digit_count=0; pw_len=at_len=0; pw_valid=at_valid=0.
  - MATCH=0, LOCKOUT=0, fail_count=0, bad_key=0.
  - Edge-detect history regs cleared to 0. A savePW/saveAT already high at reset release therefore captures on the first clock.
- Edge detect: pw_cap = savePW & ~savePW_q; at_cap = saveAT & ~saveAT_q. Holding a level high captures exactly once.
- Entry buffer (N_DIGITS x 4 bits plus count):
  - KEY_VALID, digit<=9, count<N_DIGITS: digit shifts in at the least-significant nibble; count+1.
  - Digit>9, or count==N_DIGITS: buffer unchanged; bad_key pulses the next cycle.
  - CLEAR: count=0, buffer=0. CLEAR beats a same-cycle KEY_VALID, and that key is dropped silently.
- Capture:
  - pw_cap: pw_reg<=buffer, pw_len<=count, pw_valid<=1, at_valid<=0.
  - at_cap: at_reg<=buffer, at_len<=count, at_valid<=1.
  - Either capture clears the entry buffer in the same edge.
  - A same-cycle KEY_VALID is dropped: no shift, no bad_key.
  - pw_cap and at_cap in the same cycle: pw_cap wins, at_cap is ignored.
- MATCH is combinational from registers: pw_valid & at_valid & (pw_len==at_len) & (pw_reg==at_reg) & ~LOCKOUT. It is valid the cycle after at_cap, i.e. while the FSM still holds saveAT.
- Attempt evaluation happens on at_cap, comparing the buffer directly against pw_reg/pw_len:
  - Equal, with pw_valid=1: fail_count<=0.
  - Otherwise: fail_count increments, saturating at 15.
  - If the new fail_count reaches MAX_FAILS, enter LOCKED_OUT.
  - at_cap with pw_valid=0 counts as a failure.
- Lockout state machine, states NORMAL and LOCKED_OUT:
  - NORMAL -> LOCKED_OUT: at_cap with failure reaching MAX_FAILS. Timer loads LOCKOUT_CYCLES-1; LOCKOUT=1 from the next cycle.
  - In LOCKED_OUT:
    - KEY_VALID is ignored and does not pulse bad_key.
    - at_cap still loads at_reg, but MATCH is forced 0 and fail_count is frozen.
    - pw_cap is honoured.
    - CLEAR is honoured.
  - LOCKED_OUT -> NORMAL: timer==0. fail_count<=0 and LOCKOUT=0 on that edge. LOCKOUT is high for exactly LOCKOUT_CYCLES cycles.
- pw_cap in NORMAL does not clear fail_count.
- Reset mid-lockout returns to NORMAL immediately.

Decomposition:
- Package safe_pkg:
  - digit_t (logic [3:0])
  - DIGIT_MAX=9
  - lock_state_t enum {NORMAL, LOCKED_OUT}
  - code_t as parameterised packed array of digit_t (N_DIGITS from package default)
- Sub-module: safe_entry_buf. It owns the entry buffer shift register, count, digit validation, bad_key, and the clear/capture priority. It outputs buffer and count. The top level owns edge detect, the pw/at registers, the compare, the fail counter and the lockout FSM.

Test Plan:
1. Reset, enter 1,2,3,4, pulse savePW (hold 5 cycles) -> single capture; pw_len=4, digit_count=0. Enter 1,2,3,4, raise saveAT -> MATCH=1 one cycle later, fail_count=0.
2. PW=1234. Attempt 1235 -> MATCH=0, fail_count=1. Attempt 12 -> fail_count=2. Attempt 1234 -> MATCH=1, fail_count=0.
3. PW=1234, MAX_FAILS=3, LOCKOUT_CYCLES=8. Three wrong attempts -> LOCKOUT high exactly 8 cycles. Keys ignored and correct attempt gives MATCH=0 during lockout. After expiry fail_count=0 and a correct attempt gives MATCH=1.
4. Enter 5 digits with N_DIGITS=4 -> 5th digit dropped, bad_key pulses once. KEY_DIGIT=0xA -> bad_key, count unchanged. CLEAR with KEY_VALID same cycle -> count=0.
5. KEY_VALID coincident with saveAT rise -> key dropped, buffer empty after. savePW and saveAT rising together -> password captured, attempt ignored, at_valid=0, MATCH=0.
6. Drop RESETN mid-lockout and mid-entry -> LOCKOUT, MATCH, digit_count, fail_count all 0 asynchronously. Attempt before any password -> MATCH=0, fail_count=1.
